alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Execute-stage ALU with integrated control decode for the MIPS datapath. Decodes `ALUop`/`funct` into a 4-bit ALU control code and executes the operation. Single-cycle ops (add, sub, and, or, slt) complete in one cycle. Unsigned multiply and divide run as WIDTH-cycle iterative operations behind a valid/ready handshake, and the upper product or remainder is returned on `hi`.

## Interface
- `WIDTH`, 32: operand, result and `hi` width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  operation request; accepted on a cycle where `valid_in && ready`.
- `ALUop`  in  2  main-decoder ALU op (control_signal[5:4]).
- `funct`  in  6  R-type funct field.
- `a`  in  WIDTH  operand A (rs).
- `b`  in  WIDTH  operand B (rt/imm).
- `ready`  out  1  unit idle, can accept.
- `valid_out`  out  1  one-cycle pulse: `result`/`hi`/flags valid.
- `control_out`  out  4  registered decoded ALU control code of last accepted op.
- `result`  out  WIDTH  main result (low product / quotient).
- `hi`  out  WIDTH  upper product / remainder; 0 for single-cycle ops.
- `zero`  out  1  `result == 0`.
- `illegal`  out  1  accepted op had undefined funct.
- `div_zero`  out  1  accepted divide had `b == 0`.

## Operation
- **Decode priority (first match wins):**
  - `ALUop==00` → add, code 0010.
  - `ALUop[0]==1` → sub, code 0110. `ALUop==11` is therefore sub.
  - `ALUop[1]==1` → decode on `funct`:
    - 100000 add, code 0010.
    - 100010 sub, code 0110.
    - 100100 and, code 0000.
    - 100101 or, code 0001.
    - 101010 slt, code 0111.
    - 011000 mul, code 0101.
    - 011010 div, code 0100.
    - anything else → illegal, code 0011.
- **Arithmetic:**
  - add/sub are modulo 2^WIDTH.
  - slt is a signed compare; result = {0…,1} or 0.
  - mul is unsigned: {hi,result} = a*b, full 2·WIDTH bits.
  - div is unsigned: result = a/b, hi = a%b.
- **FSM states:**
  - IDLE: `ready=1`. On accept:
    - single-cycle op or illegal → compute, register outputs, go to IDLE.
    - mul → MUL.
    - div with b≠0 → DIV.
    - div with b==0 → register result=all-ones, hi=a, div_zero=1, go to IDLE.
  - MUL: shift-add, one multiplier bit per cycle, iteration counter 0..WIDTH-1. When the count reaches WIDTH-1 → DONE.
  - DIV: restoring divide, one quotient bit per cycle, same counter. When the count reaches WIDTH-1 → DONE.
  - DONE: drive final `result`/`hi`, pulse `valid_out`, go to IDLE.
- Operands and decoded op are latched at accept. Input changes during MUL/DIV have no effect.
- `valid_in` while `ready=0` is ignored; the requester must hold it.
- Illegal op: `result=0`, `hi=0`, `illegal=1`, `valid_out` pulses.
- `result`, `hi`, `control_out`, `zero`, `illegal`, `div_zero` hold their values until the next completion.
- **Reset:**
  - All outputs go to 0 and the state goes to IDLE. `ready=0` while `rst` is high; `ready=1` on the first cycle after release.
  - Reset mid-MUL/DIV aborts the operation with no `valid_out`.

## Timing
- Single-cycle op accepted at edge N: `valid_out=1` and results valid in cycle N+1. `ready` stays 1, so back-to-back ops are accepted every cycle.
- Div-by-zero has the same 1-cycle latency.
- mul/div accepted at edge N:
  - `ready=0` from cycle N+1.
  - `valid_out` pulses in cycle N+WIDTH+1 (WIDTH iterations + DONE).
  - `ready=1` again in cycle N+WIDTH+2.
- `valid_out` is high for exactly one cycle per accepted op.
- `zero` is derived from the registered `result` and is valid with `valid_out`.

## Test plan
- **Add:** ALUop=10, funct=100000, a=5, b=7 → next cycle `valid_out=1`, result=12, hi=0, control_out=0010, zero=0. Follow back-to-back with sub 7−7 → result=0, zero=1.
- **slt and ALUop 11:**
  - funct=101010, a=0xFFFFFFFD, b=2 → result=1.
  - Same funct with ALUop=11 → sub, result=0xFFFFFFFB.
- **Mul:**
  - a=0xFFFFFFFF, b=2 → `ready` low for 33 cycles; `valid_out` 33 cycles after accept; result=0xFFFFFFFE, hi=1, control_out=0101.
  - Toggling `valid_in` and operands during the operation changes nothing.
- **Div:**
  - a=100, b=7 → result=14, hi=2 after 33 cycles.
  - a=9, b=0 → next cycle result=0xFFFFFFFF, hi=9, div_zero=1.
- **Illegal:** funct=111111 with ALUop=10 → next cycle illegal=1, result=0, control_out=0011.
- **Reset mid-mul:** assert `rst` 10 cycles into a mul.
  - All outputs 0 and no `valid_out` pulse.
  - `ready=1` the cycle after release.
  - A following add 1+1 returns 2 with 1-cycle latency.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: request/response bundle for the execute-stage ALU.
//
// Handshake: a request is accepted on a rising edge where valid_in && ready.
// The requester holds valid_in and its operands until ready is seen high.
// valid_out is a one-cycle pulse per accepted op; result/hi/flags/control_out
// hold their values until the next completion.
//
// Signals:
//   valid_in, ALUop[1:0], funct[5:0], a, b   requester -> ALU
//   ready, valid_out, control_out[3:0],
//   result, hi, zero, illegal, div_zero      ALU -> requester
//   fsm_state[1:0]                           ALU -> observer (0 IDLE, 1 MUL, 2 DIV, 3 DONE)
interface alu_ctrl_seq_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic [1:0]       ALUop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             valid_out;
    logic [3:0]       control_out;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             illegal;
    logic             div_zero;
    logic [1:0]       fsm_state;

    modport master (
        output valid_in, ALUop, funct, a, b,
        input  ready, valid_out, control_out, result, hi, zero, illegal, div_zero, fsm_state
    );

    modport slave (
        input  valid_in, ALUop, funct, a, b,
        output ready, valid_out, control_out, result, hi, zero, illegal, div_zero, fsm_state
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: execute-stage ALU with integrated ALUop/funct decode.
// add/sub/and/or/slt complete one cycle after accept; unsigned mul
// (shift-add) and div (restoring) take WIDTH iterations plus a DONE cycle.
// The upper product / remainder is returned on hi.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   alu_ctrl_seq_if.slave (request, response, fsm_state debug)
module alu_ctrl_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_ctrl_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_ILL = 4'b0011;
    localparam logic [3:0] C_DIV = 4'b0100;
    localparam logic [3:0] C_MUL = 4'b0101;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic [3:0]       dec_code;
    logic             accept;
    logic             last_iter;

    // Iteration registers shared by mul and div:
    //   mul: opnd = multiplicand, hi_w:lo_w = partial product / multiplier
    //   div: opnd = divisor, hi_w = partial remainder, lo_w = dividend -> quotient
    logic [WIDTH-1:0] opnd_q, hi_w_q, lo_w_q;
    logic [WIDTH-1:0] opnd_next, hi_w_next, lo_w_next;
    logic [CW-1:0]    cnt_q, cnt_next;
    logic [3:0]       op_q, op_next;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;

    // Completion values, registered onto the outputs when done_now is set.
    logic             done_now;
    logic [WIDTH-1:0] res_next, hi_next;
    logic             ill_next, dz_next;

    assign accept        = bus.valid_in && bus.ready;
    assign last_iter     = (cnt_q == CW'(WIDTH - 1));
    assign bus.ready     = (state == IDLE) && !rst;
    assign bus.fsm_state = state;

    // Priority decode: ALUop 00 add, ALUop[0] sub (so 11 is sub), else funct.
    always_comb begin
        dec_code = C_ILL;
        if (bus.ALUop == 2'b00) begin
            dec_code = C_ADD;
        end else if (bus.ALUop[0]) begin
            dec_code = C_SUB;
        end else begin
            case (bus.funct)
                6'b100000: dec_code = C_ADD;
                6'b100010: dec_code = C_SUB;
                6'b100100: dec_code = C_AND;
                6'b100101: dec_code = C_OR;
                6'b101010: dec_code = C_SLT;
                6'b011000: dec_code = C_MUL;
                6'b011010: dec_code = C_DIV;
                default:   dec_code = C_ILL;
            endcase
        end
    end

    // One shift-add step: add multiplicand when the current multiplier bit is
    // set, then shift the whole {carry, hi_w, lo_w} right by one.
    assign mul_sum   = {1'b0, hi_w_q} + (lo_w_q[0] ? {1'b0, opnd_q} : '0);
    // One restoring-divide step: bring the next dividend bit into the
    // remainder and trial-subtract the divisor.
    assign div_shift = {hi_w_q, lo_w_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_now   = 1'b0;
        res_next   = '0;
        hi_next    = '0;
        ill_next   = 1'b0;
        dz_next    = 1'b0;
        opnd_next  = opnd_q;
        hi_w_next  = hi_w_q;
        lo_w_next  = lo_w_q;
        cnt_next   = cnt_q;
        op_next    = op_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_next  = dec_code;
                    cnt_next = '0;
                    case (dec_code)
                        C_ADD: begin done_now = 1'b1; res_next = bus.a + bus.b; end
                        C_SUB: begin done_now = 1'b1; res_next = bus.a - bus.b; end
                        C_AND: begin done_now = 1'b1; res_next = bus.a & bus.b; end
                        C_OR:  begin done_now = 1'b1; res_next = bus.a | bus.b; end
                        C_SLT: begin
                            done_now = 1'b1;
                            res_next = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                        end
                        C_MUL: begin
                            state_next = MUL;
                            opnd_next  = bus.a;
                            hi_w_next  = '0;
                            lo_w_next  = bus.b;
                        end
                        C_DIV: begin
                            if (bus.b == '0) begin
                                done_now = 1'b1;
                                res_next = '1;
                                hi_next  = bus.a;
                                dz_next  = 1'b1;
                            end else begin
                                state_next = DIV;
                                opnd_next  = bus.b;
                                hi_w_next  = '0;
                                lo_w_next  = bus.a;
                            end
                        end
                        default: begin done_now = 1'b1; ill_next = 1'b1; end
                    endcase
                end
            end
            MUL: begin
                hi_w_next = mul_sum[WIDTH:1];
                lo_w_next = {mul_sum[0], lo_w_q[WIDTH-1:1]};
                cnt_next  = cnt_q + 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                    done_now   = 1'b1;
                    res_next   = lo_w_next;
                    hi_next    = hi_w_next;
                end
            end
            DIV: begin
                hi_w_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                lo_w_next = {lo_w_q[WIDTH-2:0], ~div_diff[WIDTH]};
                cnt_next  = cnt_q + 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                    done_now   = 1'b1;
                    res_next   = lo_w_next;
                    hi_next    = hi_w_next;
                end
            end
            DONE: begin
                // Outputs were registered on the final iteration edge; this
                // cycle carries the valid_out pulse.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_q <= '0;
            hi_w_q <= '0;
            lo_w_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
        end else begin
            opnd_q <= opnd_next;
            hi_w_q <= hi_w_next;
            lo_w_q <= lo_w_next;
            cnt_q  <= cnt_next;
            op_q   <= op_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_out   <= 1'b0;
            bus.result      <= '0;
            bus.hi          <= '0;
            bus.zero        <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.div_zero    <= 1'b0;
            bus.control_out <= '0;
        end else begin
            bus.valid_out <= done_now;
            if (done_now) begin
                bus.result      <= res_next;
                bus.hi          <= hi_next;
                bus.zero        <= (res_next == '0);
                bus.illegal     <= ill_next;
                bus.div_zero    <= dz_next;
                bus.control_out <= op_next;
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed self-checking bench for alu_ctrl_seq (WIDTH=32).
// Expected values are hand-computed constants in the stimulus calls.
module tb_alu_ctrl_seq;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [W-1:0] exp_q[$];

    alu_ctrl_seq_if #(.WIDTH(W)) bus ();

    alu_ctrl_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    // Single-cycle op: accept on the next edge, results one cycle later.
    // Consecutive calls are back-to-back (valid_in re-raised before the next edge).
    task automatic do_single(input string tag, input logic [1:0] op, input logic [5:0] fn,
                             input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                             input logic [3:0] exp_code, input logic exp_zero,
                             input logic exp_ill, input logic exp_dz);
        logic [W-1:0] e;
        check({tag, ".ready"}, bus.ready, 1'b1);
        bus.valid_in = 1'b1;
        bus.ALUop    = op;
        bus.funct    = fn;
        bus.a        = av;
        bus.b        = bv;
        exp_q.push_back(exp_res);
        step();
        bus.valid_in = 1'b0;
        check({tag, ".valid_out"}, bus.valid_out, 1'b1);
        e = exp_q.pop_front();
        check({tag, ".result"}, bus.result, e);
        check({tag, ".hi"}, bus.hi, exp_hi);
        check({tag, ".code"}, bus.control_out, exp_code);
        check({tag, ".zero"}, bus.zero, exp_zero);
        check({tag, ".illegal"}, bus.illegal, exp_ill);
        check({tag, ".div_zero"}, bus.div_zero, exp_dz);
    endtask

    // Multi-cycle op: optionally scribbles on the inputs while busy.
    task automatic do_multi(input string tag, input logic [5:0] fn,
                            input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                            input logic [3:0] exp_code, input logic toggle);
        int lat;
        int busy;
        logic seen;
        logic [W-1:0] e;
        check({tag, ".ready"}, bus.ready, 1'b1);
        bus.valid_in = 1'b1;
        bus.ALUop    = 2'b10;
        bus.funct    = fn;
        bus.a        = av;
        bus.b        = bv;
        exp_q.push_back(exp_res);
        step();
        if (!toggle) bus.valid_in = 1'b0;
        lat  = 1;
        busy = 0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!bus.ready) busy++;
            if (bus.valid_out) begin
                seen = 1'b1;
                break;
            end
            if (toggle) begin
                bus.valid_in = k[0];
                bus.ALUop    = 2'b00;
                bus.funct    = 6'b100000;
                bus.a        = 32'h1234_0000 + k;
                bus.b        = 32'h0000_0100 * k;
            end
            step();
            lat++;
        end
        bus.valid_in = 1'b0;
        check({tag, ".seen"}, seen, 1'b1);
        check({tag, ".latency"}, lat, W + 1);
        check({tag, ".busy"}, busy, W + 1);
        check({tag, ".state_done"}, bus.fsm_state, 2'd3);
        e = exp_q.pop_front();
        check({tag, ".result"}, bus.result, e);
        check({tag, ".hi"}, bus.hi, exp_hi);
        check({tag, ".code"}, bus.control_out, exp_code);
        check({tag, ".div_zero"}, bus.div_zero, 1'b0);
        step();
        check({tag, ".ready_after"}, bus.ready, 1'b1);
        check({tag, ".pulse_end"}, bus.valid_out, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.ALUop    = 2'b00;
        bus.funct    = 6'b000000;
        bus.a        = '0;
        bus.b        = '0;
        repeat (3) step();

        check("rst.ready", bus.ready, 1'b0);
        check("rst.valid_out", bus.valid_out, 1'b0);
        check("rst.result", bus.result, 0);
        check("rst.zero", bus.zero, 1'b0);
        check("rst.code", bus.control_out, 4'b0000);
        check("rst.state", bus.fsm_state, 2'd0);
        rst = 1'b0;
        #1;
        check("rel.ready", bus.ready, 1'b1);

        // add then back-to-back sub
        do_single("add",   2'b10, 6'b100000, 32'd5, 32'd7, 32'd12, 0, 4'b0010, 1'b0, 1'b0, 1'b0);
        do_single("sub0",  2'b10, 6'b100010, 32'd7, 32'd7, 32'd0,  0, 4'b0110, 1'b1, 1'b0, 1'b0);
        do_single("slt",   2'b10, 6'b101010, 32'hFFFF_FFFD, 32'd2, 32'd1, 0, 4'b0111, 1'b0, 1'b0, 1'b0);
        do_single("op11",  2'b11, 6'b101010, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFB, 0, 4'b0110, 1'b0, 1'b0, 1'b0);
        do_single("slt_s", 2'b10, 6'b101010, 32'd2, 32'hFFFF_FFFF, 32'd0, 0, 4'b0111, 1'b1, 1'b0, 1'b0);
        do_single("op00",  2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 4'b0010, 1'b1, 1'b0, 1'b0);
        do_single("op01",  2'b01, 6'b100100, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 4'b0110, 1'b0, 1'b0, 1'b0);
        do_single("and",   2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
        do_single("or",    2'b10, 6'b100101, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0, 4'b0001, 1'b0, 1'b0, 1'b0);
        do_single("ill",   2'b10, 6'b111111, 32'd9, 32'd3, 32'd0, 0, 4'b0011, 1'b1, 1'b1, 1'b0);
        do_single("divz",  2'b10, 6'b011010, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 4'b0100, 1'b0, 1'b0, 1'b1);
        step();
        check("single.pulse_end", bus.valid_out, 1'b0);
        check("single.hold", bus.result, 32'hFFFF_FFFF);

        // multi-cycle ops
        do_multi("mul",    6'b011000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 4'b0101, 1'b1);
        do_multi("mulmax", 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b0101, 1'b0);
        do_multi("div",    6'b011010, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0100, 1'b1);
        do_multi("divbig", 6'b011010, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 4'b0100, 1'b0);
        do_single("add_hi0", 2'b10, 6'b100000, 32'd1, 32'd2, 32'd3, 0, 4'b0010, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a mul
        bus.valid_in = 1'b1;
        bus.ALUop    = 2'b10;
        bus.funct    = 6'b011000;
        bus.a        = 32'd3;
        bus.b        = 32'd5;
        step();
        bus.valid_in = 1'b0;
        check("rmul.state", bus.fsm_state, 2'd1);
        repeat (9) step();
        rst = 1'b1;
        step();
        check("rmul.ready_rst", bus.ready, 1'b0);
        check("rmul.result", bus.result, 0);
        check("rmul.code", bus.control_out, 4'b0000);
        check("rmul.valid_out", bus.valid_out, 1'b0);
        check("rmul.state_idle", bus.fsm_state, 2'd0);
        step();
        rst = 1'b0;
        #1;
        check("rmul.ready_rel", bus.ready, 1'b1);
        pulses = 0;
        for (int k = 0; k < W + 5; k++) begin
            step();
            if (bus.valid_out) pulses++;
        end
        check("rmul.no_pulse", pulses, 0);
        do_single("post_rst_add", 2'b10, 6'b100000, 32'd1, 32'd1, 32'd2, 0, 4'b0010, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
